// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM encoding, display constants and
// the wrap-aware count step used by the core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int COUNT_W = 14;
  localparam logic [COUNT_W-1:0] MAX_COUNT  = 14'd9999;
  localparam logic [COUNT_W-1:0] PAUSE_CODE = 14'd11111;

  // Next count value; the range is closed at both ends so it never leaves 0..9999.
  function automatic logic [COUNT_W-1:0] step_count(input logic [COUNT_W-1:0] c,
                                                    input logic down);
    if (down) return (c == '0) ? MAX_COUNT : c - COUNT_W'(1);
    else      return (c >= MAX_COUNT) ? '0 : c + COUNT_W'(1);
  endfunction

  function automatic logic is_wrap(input logic [COUNT_W-1:0] c, input logic down);
    if (down) return (c == '0);
    else      return (c >= MAX_COUNT);
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// Enable-gated divide-by-DIV prescaler producing a one-clock tick on the
// DIV-th enabled clock; clr zeroes the count and suppresses the tick.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = en && !clr && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = at_last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: IDLE/RUN/PAUSE control, 0..9999 up/down count with wrap
// pulse, free-running display scan tick and blinking pause display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int COUNT_HZ = 10,
  parameter int BLINK_HZ = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_clear,
  input  logic               mode_down,
  output logic               scan_tick,
  output logic [COUNT_W-1:0] disp_data,
  output logic [1:0]         state,
  output logic               wrap
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

  state_e             state_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               wrap_q, wrap_d;
  logic               blink_phase_q;

  logic count_tick, blink_tick;
  logic pause_entry, blink_clr;

  assign pause_entry = (state_q == ST_RUN) && btn_run && !btn_clear;
  assign blink_clr   = pause_entry || btn_clear;

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  tick_gen #(.DIV(COUNT_DIV)) u_count (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .clr   (btn_clear),
    .tick  (count_tick)
  );

  // Restarting on every pause entry makes the blink always open with the count shown.
  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_PAUSE),
    .clr   (blink_clr),
    .tick  (blink_tick)
  );

  assign count_d = step_count(count_q, mode_down);
  assign wrap_d  = is_wrap(count_q, mode_down);

  // A run press coinciding with a count tick both updates the count and pauses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      wrap_q        <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (btn_clear) begin
        state_q       <= ST_IDLE;
        count_q       <= '0;
        blink_phase_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (btn_run) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (count_tick) begin
              count_q <= count_d;
              wrap_q  <= wrap_d;
            end
            if (btn_run) begin
              state_q       <= ST_PAUSE;
              blink_phase_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (btn_run)         state_q       <= ST_RUN;
            else if (blink_tick) blink_phase_q <= ~blink_phase_q;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign disp_data = (state_q == ST_PAUSE && blink_phase_q) ? PAUSE_CODE : count_q;
  assign state     = state_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a slow instance at the reference rates
// and a fast instance (one count per clock) share the same button stimulus.
module tb_stopwatch_core;

  typedef struct packed {
    logic [1:0]  st;
    logic [13:0] disp;
    logic        wrap;
    logic        scan;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_clear = 1'b0;
  logic        mode_down = 1'b0;
  logic        scan0, scan1, wrap0, wrap1;
  logic [13:0] disp0, disp1;
  logic [1:0]  st0, st1;

  int compared = 0;
  int mismatched = 0;
  int scanPulses0 = 0;
  bit curDown = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state per instance: 0 = slow, 1 = fast.
  int mSt[2], mCnt[2], mRun[2], mBlink[2], mPhase[2], mEdges[2];
  int cDiv[2] = '{100, 1};
  int bDiv[2] = '{500, 50};
  int sDiv[2] = '{10, 10};

  always #5 clk = ~clk;

  stopwatch_core #(.CLK_HZ(1000), .SCAN_HZ(100), .COUNT_HZ(10), .BLINK_HZ(1)) u_main (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_clear(btn_clear),
    .mode_down(mode_down), .scan_tick(scan0), .disp_data(disp0), .state(st0), .wrap(wrap0)
  );

  stopwatch_core #(.CLK_HZ(100), .SCAN_HZ(10), .COUNT_HZ(100), .BLINK_HZ(1)) u_fast (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_clear(btn_clear),
    .mode_down(mode_down), .scan_tick(scan1), .disp_data(disp1), .state(st1), .wrap(wrap1)
  );

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mSt[d] = 0; mCnt[d] = 0; mRun[d] = 0; mBlink[d] = 0; mPhase[d] = 0; mEdges[d] = 0;
    end
  endtask

  task automatic modelStep(input int d, input bit run, input bit clr, input bit down,
                           output exp_t e);
    bit tickNow = 1'b0;
    bit wrapNow = 1'b0;
    mEdges[d] = mEdges[d] + 1;
    if (clr) begin
      mSt[d] = 0; mCnt[d] = 0; mRun[d] = 0; mPhase[d] = 0; mBlink[d] = 0;
    end else if (mSt[d] == 1) begin
      mRun[d] = mRun[d] + 1;
      if (mRun[d] >= cDiv[d]) begin
        mRun[d] = 0;
        tickNow = 1'b1;
      end
      if (tickNow) begin
        if (down) begin
          if (mCnt[d] == 0) begin mCnt[d] = 9999; wrapNow = 1'b1; end
          else mCnt[d] = mCnt[d] - 1;
        end else begin
          if (mCnt[d] == 9999) begin mCnt[d] = 0; wrapNow = 1'b1; end
          else mCnt[d] = mCnt[d] + 1;
        end
      end
      if (run) begin
        mSt[d] = 2; mPhase[d] = 0; mBlink[d] = 0;
      end
    end else if (mSt[d] == 2) begin
      if (run) mSt[d] = 1;
      else begin
        mBlink[d] = mBlink[d] + 1;
        if (mBlink[d] >= bDiv[d]) begin
          mBlink[d] = 0;
          mPhase[d] = 1 - mPhase[d];
        end
      end
    end else if (run) begin
      mSt[d] = 1;
    end
    e.st   = 2'(mSt[d]);
    e.disp = (mSt[d] == 2 && mPhase[d] == 1) ? 14'd11111 : 14'(mCnt[d]);
    e.wrap = wrapNow;
    e.scan = ((mEdges[d] % sDiv[d]) == sDiv[d] - 1);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit run, input bit clr);
    exp_t e0, e1;
    @(negedge clk);
    reset     = 1'b0;
    btn_run   = run;
    btn_clear = clr;
    mode_down = curDown;
    modelStep(0, run, clr, curDown, e0);
    modelStep(1, run, clr, curDown, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0);
  endtask

  // Lets the edge consuming the last applied stimulus happen, then settles.
  task automatic sampleNow();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " main state"}, st0, 0);
    checkOutput({tag, " main disp"}, disp0, 0);
    checkOutput({tag, " main wrap"}, wrap0, 0);
    checkOutput({tag, " main scan"}, scan0, 0);
    checkOutput({tag, " fast state"}, st1, 0);
    checkOutput({tag, " fast disp"}, disp1, 0);
    checkOutput({tag, " fast wrap"}, wrap1, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; btn_run = 1'b0; btn_clear = 1'b0;
    #1;
    checkResetValues("sync reset");
    modelReset();
    @(negedge clk);
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #3;
    reset = 1'b1; btn_run = 1'b0; btn_clear = 1'b0;
    #1;
    checkResetValues("async reset");
    modelReset();
    @(negedge clk);
  endtask

  task automatic compareExp(input string name, input exp_t e, input logic [1:0] st,
                            input logic [13:0] disp, input logic wr, input logic sc);
    compared++;
    if (st !== e.st || disp !== e.disp || wr !== e.wrap || sc !== e.scan) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got st=%0d disp=%0d wrap=%0b scan=%0b, expected st=%0d disp=%0d wrap=%0b scan=%0b",
               name, $time, st, disp, wr, sc, e.st, e.disp, e.wrap, e.scan);
    end
  endtask

  // Monitor: pops one expected entry per consumed clock edge and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && scan0) scanPulses0++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compareExp("main cycle", e, st0, disp0, wrap0, scan0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compareExp("fast cycle", e, st1, disp1, wrap1, scan1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    resetDut();

    // Idle after reset: nothing moves except the scan tick.
    scanPulses0 = 0;
    idle(1000);
    sampleNow();
    checkOutput("idle scan pulses", scanPulses0, 100);
    checkOutput("idle state", st0, 0);
    checkOutput("idle disp", disp0, 0);

    // Run one second, then pause and watch the blink.
    applyStimulus(1'b1, 1'b0);
    idle(1000);
    sampleNow();
    checkOutput("run state", st0, 1);
    checkOutput("run disp", disp0, 10);
    applyStimulus(1'b1, 1'b0);
    idle(499);
    sampleNow();
    checkOutput("pause state", st0, 2);
    checkOutput("pause first half disp", disp0, 10);
    idle(1);
    sampleNow();
    checkOutput("pause blink disp", disp0, 11111);
    idle(500);
    sampleNow();
    checkOutput("pause blink back disp", disp0, 10);

    // Pause with prescaler at 40: the resumed run needs only 60 more clocks.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    idle(39);
    applyStimulus(1'b1, 1'b0);
    idle(20);
    applyStimulus(1'b1, 1'b0);
    idle(59);
    sampleNow();
    checkOutput("resume before tick disp", disp0, 0);
    idle(1);
    sampleNow();
    checkOutput("resume tick disp", disp0, 1);

    // Clear wins over a simultaneous run press.
    applyStimulus(1'b1, 1'b1);
    sampleNow();
    checkOutput("clear+run state", st0, 0);
    checkOutput("clear+run disp", disp0, 0);
    idle(5);
    sampleNow();
    checkOutput("clear+run stays idle", st0, 0);

    // Fast instance counts every clock: up through 9999 and wrap both ways.
    curDown = 1'b0;
    applyStimulus(1'b1, 1'b0);
    idle(9999);
    sampleNow();
    checkOutput("fast at max disp", disp1, 9999);
    checkOutput("fast at max wrap", wrap1, 0);
    idle(1);
    sampleNow();
    checkOutput("fast up wrap disp", disp1, 0);
    checkOutput("fast up wrap pulse", wrap1, 1);
    idle(1);
    sampleNow();
    checkOutput("fast wrap single pulse", wrap1, 0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    curDown = 1'b1;
    idle(1);
    sampleNow();
    checkOutput("fast down wrap disp", disp1, 9999);
    checkOutput("fast down wrap pulse", wrap1, 1);
    idle(1);
    sampleNow();
    checkOutput("fast down step disp", disp1, 9998);

    // Randomized button traffic checked by the scoreboard.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r >= 500 && r < 506) curDown = ~curDown;
      applyStimulus(r < 4, r == 999);
    end

    // Asynchronous reset landing mid-run, between clock edges.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    idle(150);
    asyncReset();

    curDown = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 999);
      applyStimulus(r < 5, r == 999);
    end
    idle(2);
    sampleNow();
    #20;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, digit-scan tick rate.
REQ-003 SHALL have parameter COUNT_HZ, default 10, count increment rate.
REQ-004 SHALL have parameter BLINK_HZ, default 1, pause-blink full-period rate.
REQ-005 SHALL have port clk  input  1  system clock, rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port btn_run  input  1  run/stop request, one-clk pulse, debounced upstream.
REQ-008 SHALL have port btn_clear  input  1  clear request, one-clk pulse, debounced upstream.
REQ-009 SHALL have port mode_down  input  1  0 = count up, 1 = count down.
REQ-010 SHALL have port scan_tick  output  1  one-clk pulse at SCAN_HZ, drives display digit scan.
REQ-011 SHALL have port disp_data  output  14  value to display, 0..9999 or pause code 11111.
REQ-012 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2.
REQ-013 SHALL have port wrap  output  1  one-clk pulse on count wrap-around.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE; encoding 3 unused, recovers to IDLE next clk.
REQ-015 SHALL transition IDLE->RUN, RUN->PAUSE, PAUSE->RUN on btn_run.
REQ-016 SHALL go to IDLE with count=0 on btn_clear from any state; clear wins over simultaneous btn_run.
REQ-017 SHALL generate scan_tick free-running every CLK_HZ/SCAN_HZ clks, independent of FSM state and clear.
REQ-018 SHALL advance the count prescaler only in RUN, emitting count_tick every CLK_HZ/COUNT_HZ clks; prescaler holds in PAUSE, zeroes on clear.
REQ-019 SHALL, on count_tick with mode_down=0, increment count; 9999 -> 0 with wrap=1 that same clk.
REQ-020 SHALL, on count_tick with mode_down=1, decrement count; 0 -> 9999 with wrap=1 that same clk.
REQ-021 SHALL treat a mode_down change as effective from the next count_tick; count unchanged at the switch.
REQ-022 SHALL keep count in 14 bits, never outside 0..9999.
REQ-023 SHALL zero blink_phase and the blink prescaler on every entry to PAUSE, then toggle blink_phase every CLK_HZ/(2*BLINK_HZ) clks while in PAUSE.
REQ-024 SHALL drive disp_data = count in IDLE and RUN; in PAUSE, count when blink_phase=0, 11111 when blink_phase=1.
REQ-025 SHALL derive disp_data combinationally from registered count/state/blink_phase: zero added latency, glitch-free at register edges.
REQ-026 SHALL make btn_run in the same clk as count_tick (RUN) apply both: count updates, state becomes PAUSE.

Reset
REQ-027 SHALL on reset assert immediately: state=IDLE, count=0, all prescalers=0, blink_phase=0, scan_tick=0, wrap=0, disp_data=0.
REQ-028 SHALL ignore btn_run/btn_clear while reset is high; first clk after release is in IDLE.

Structure
REQ-029 SHALL place state encodings, PAUSE_CODE=11111 and MAX_COUNT=9999 in shared package stopwatch_pkg.
REQ-030 SHALL use one sub-module tick_gen (parameter DIV; inputs clk, reset, en, clr; output tick pulse), instantiated for scan, count and blink prescalers.

Verification (CLK_HZ=1000, SCAN_HZ=100, COUNT_HZ=10, BLINK_HZ=1)
REQ-031 SHALL check: reset release, no buttons, 1000 clks -> state=0, disp_data=0, scan_tick every 10 clks (100 pulses).
REQ-032 SHALL check: btn_run, 1000 clks -> state=1, disp_data=10; btn_run -> state=2, disp_data toggles 10/11111 every 500 clks, starting with 10.
REQ-033 SHALL check: preload by running to 9999, one more count_tick -> disp_data=0, wrap single pulse; mode_down=1 at 0 -> next tick 9999 with wrap.
REQ-034 SHALL check: btn_run and btn_clear same clk while RUN -> state=0, count=0, no RUN/PAUSE entry.
REQ-035 SHALL check: pause at prescaler=40, resume -> next increment after 60 clks, not 100.
REQ-036 SHALL check: reset asserted mid-RUN, asynchronously between edges -> outputs at reset values before next clk edge.
